// File: rtl/count_updn.sv
// Parametrised up/down counter with clamped parallel load, programmable
// terminal value, wrap or saturate at the range ends, and a carry/borrow pulse.
module count_updn #(
  parameter int          WIDTH    = 6,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             LOAD,
  input  logic             UP,
  input  logic [WIDTH-1:0] DATA,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             CARRY
);

  localparam logic [WIDTH-1:0] max_v = WIDTH'(MAX_VAL);

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;

  assign at_top   = (COUNT == max_v);
  assign at_bot   = (COUNT == '0);
  assign TC       = UP ? at_top : at_bot;
  assign load_val = (DATA > max_v) ? max_v : DATA;

  // Range ends are decided against MAX_VAL, so COUNT never leaves 0..MAX_VAL.
  always_comb begin
    count_nxt = COUNT;
    carry_nxt = 1'b0;
    if (LOAD) begin
      count_nxt = load_val;
    end else if (ENABLE) begin
      if (TC) begin
        carry_nxt = 1'b1;
        if (!SATURATE) begin
          count_nxt = UP ? '0 : max_v;
        end
      end else begin
        count_nxt = UP ? (COUNT + 1'b1) : (COUNT - 1'b1);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      COUNT <= '0;
      CARRY <= 1'b0;
    end else begin
      COUNT <= count_nxt;
      CARRY <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_count_updn.sv
// Bench for count_updn: a wrap-mode instance (MAX_VAL=9) and a saturate-mode
// instance (default 6-bit range) share inputs and are checked against a model.
module tb_count_updn;

  logic       CLOCK = 1'b0;
  logic       RESET, ENABLE, LOAD, UP;
  logic [5:0] DATA;
  logic [5:0] cnt_a, cnt_b;
  logic       tc_a, tc_b, car_a, car_b;

  int total = 0;
  int bad   = 0;

  int mx[2] = '{9, 63};
  bit st[2] = '{1'b0, 1'b1};
  int m_cnt[2];
  int m_car[2];

  always #5 CLOCK = ~CLOCK;

  count_updn #(.WIDTH(6), .MAX_VAL(9), .SATURATE(1'b0)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD), .UP(UP),
    .DATA(DATA), .COUNT(cnt_a), .TC(tc_a), .CARRY(car_a)
  );

  count_updn #(.WIDTH(6), .SATURATE(1'b1)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD), .UP(UP),
    .DATA(DATA), .COUNT(cnt_b), .TC(tc_b), .CARRY(car_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Next-state rules in modulo-(MAX_VAL+1) arithmetic.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int n;
      if (RESET) begin
        m_cnt[i] = 0; m_car[i] = 0;
      end else if (LOAD) begin
        m_cnt[i] = (int'(DATA) > mx[i]) ? mx[i] : int'(DATA);
        m_car[i] = 0;
      end else if (ENABLE) begin
        if (UP) begin
          n = m_cnt[i] + 1;
          m_car[i] = (n > mx[i]) ? 1 : 0;
          m_cnt[i] = st[i] ? ((n > mx[i]) ? mx[i] : n) : (n % (mx[i] + 1));
        end else begin
          m_car[i] = (m_cnt[i] == 0) ? 1 : 0;
          m_cnt[i] = st[i] ? ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1)
                           : ((m_cnt[i] + mx[i]) % (mx[i] + 1));
        end
      end else begin
        m_car[i] = 0;
      end
    end
  endtask

  function automatic int model_tc(input int i);
    return UP ? int'(m_cnt[i] == mx[i]) : int'(m_cnt[i] == 0);
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    model_edge();
    #1;
    check("a_count", 32'(cnt_a), 32'(m_cnt[0]));
    check("a_carry", 32'(car_a), 32'(m_car[0]));
    check("b_count", 32'(cnt_b), 32'(m_cnt[1]));
    check("b_carry", 32'(car_b), 32'(m_car[1]));
  endtask

  task automatic check_tc();
    #1;
    check("a_tc", 32'(tc_a), 32'(model_tc(0)));
    check("b_tc", 32'(tc_b), 32'(model_tc(1)));
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic u, input logic [5:0] d);
    RESET = r; LOAD = l; ENABLE = e; UP = u; DATA = d;
  endtask

  initial begin
    m_cnt = '{0, 0};
    m_car = '{0, 0};
    drive(1, 1, 0, 0, 6'h2A);
    #2;

    // reset and hold
    tick(); tick();
    check("rst_count", 32'(cnt_a), 0);
    check("rst_carry", 32'(car_a), 0);
    check_tc();
    check("rst_tc_dn", 32'(tc_a), 1);
    drive(0, 0, 0, 0, 6'h2A);
    tick();
    check("hold_count", 32'(cnt_a), 0);

    // load, priority, clamp
    drive(0, 1, 1, 1, 6'd5);
    tick();
    check("load_prio", 32'(cnt_a), 5);
    drive(0, 1, 1, 1, 6'd12);
    tick();
    check("load_clamp", 32'(cnt_a), 9);
    check("load_noclamp", 32'(cnt_b), 12);

    // wrap up then down
    drive(0, 1, 0, 1, 6'd8);
    tick();
    drive(0, 0, 1, 1, 6'd0);
    tick(); check_tc();
    check("wrap_up_9", 32'(cnt_a), 9);
    check("wrap_up_tc", 32'(tc_a), 1);
    tick();
    check("wrap_up_0", 32'(cnt_a), 0);
    check("wrap_up_carry", 32'(car_a), 1);
    tick();
    check("wrap_up_1", 32'(cnt_a), 1);
    check("wrap_up_nocarry", 32'(car_a), 0);
    UP = 1'b0;
    tick(); check_tc();
    check("wrap_dn_0", 32'(cnt_a), 0);
    check("wrap_dn_tc", 32'(tc_a), 1);
    tick();
    check("wrap_dn_9", 32'(cnt_a), 9);
    check("wrap_dn_carry", 32'(car_a), 1);
    tick();
    check("wrap_dn_8", 32'(cnt_a), 8);

    // saturate
    drive(0, 1, 1, 1, 6'd62);
    tick();
    LOAD = 1'b0;
    tick();
    check("sat_63a", 32'(cnt_b), 63); check("sat_c0", 32'(car_b), 0);
    tick();
    check("sat_63b", 32'(cnt_b), 63); check("sat_c1", 32'(car_b), 1);
    tick();
    check("sat_63c", 32'(cnt_b), 63); check("sat_c2", 32'(car_b), 1);
    UP = 1'b0;
    tick();
    check("sat_dn_62", 32'(cnt_b), 62); check("sat_dn_c", 32'(car_b), 0);

    // mid-count reset and direction flip
    drive(0, 1, 0, 1, 6'd0);
    tick();
    drive(0, 0, 1, 1, 6'd0);
    tick(); tick(); tick();
    check("upto3", 32'(cnt_a), 3);
    drive(1, 1, 1, 1, 6'd33);
    tick();
    check("midrst", 32'(cnt_a), 0);
    drive(0, 0, 1, 1, 6'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("flip_count", 32'(cnt_a), (k % 2 == 0) ? 1 : 0);
      check("flip_carry", 32'(car_a), 0);
      UP = ~UP;
      check_tc();
    end

    // random
    for (int k = 0; k < 1000; k++) begin
      drive(($urandom_range(31) == 0), ($urandom_range(7) == 0),
            ($urandom_range(3) != 0), 1'($urandom), 6'($urandom));
      check_tc();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
